// File: rtl/mux_pkg.sv
// Shared constants and helpers for the round-robin lane scheduler.
// Lane count is fixed at four, so selector indices are always two bits wide.
package mux_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int LANES      = 4;
    localparam int SEL_WIDTH  = 2;

    function automatic logic [3:0] onehot2(input logic [1:0] sel);
        logic [3:0] result;
        result      = 4'b0000;
        result[sel] = 1'b1;
        return result;
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational rotating-priority picker for four requesters.
// The search starts one lane above the previous winner and wraps around.
module rr_arbiter4
    import mux_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] last,
    input  logic       en,
    output logic [3:0] win,
    output logic [1:0] win_idx,
    output logic       any
);

    logic [1:0] idx;

    // Offsets 1..4 from last; the two-bit wrap makes offset 4 land back on last.
    always_comb begin
        win     = 4'b0000;
        win_idx = 2'd0;
        any     = 1'b0;
        idx     = 2'd0;
        if (en) begin
            for (int k = 1; k <= 4; k++) begin
                idx = last + 2'(k);
                if (!any && req[idx]) begin
                    any     = 1'b1;
                    win_idx = idx;
                end
            end
        end
        if (any) begin
            win = onehot2(win_idx);
        end
    end

endmodule

// File: rtl/mux_rr_scheduler.sv
// Four-lane round-robin scheduler: one holding register per lane, a rotating
// grant pointer and a registered output word with its selector and one-hot grant.
module mux_rr_scheduler #(
    parameter int DATA_WIDTH = mux_pkg::DATA_WIDTH,
    parameter int LANES      = mux_pkg::LANES
) (
    input  logic                          clk_4f,
    input  logic                          reset,
    input  logic [LANES-1:0]              valid_in,
    input  logic [LANES*DATA_WIDTH-1:0]   data_in,
    output logic [LANES-1:0]              in_ready,
    input  logic                          out_ready,
    output logic                          valid_out,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic [mux_pkg::SEL_WIDTH-1:0] selector,
    output logic [LANES-1:0]              grant
);

    import mux_pkg::*;

    logic [LANES-1:0]      pend;
    logic [DATA_WIDTH-1:0] hold [LANES];
    logic [1:0]            last;
    logic [3:0]            win;
    logic [1:0]            win_idx;
    logic                  any;

    rr_arbiter4 u_arbiter (
        .req     (pend),
        .last    (last),
        .en      (out_ready),
        .win     (win),
        .win_idx (win_idx),
        .any     (any)
    );

    // A lane draining this cycle can accept its next word in the same cycle.
    assign in_ready = ~pend | win;

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            pend      <= '0;
            last      <= 2'd3;
            valid_out <= 1'b0;
            data_out  <= '0;
            selector  <= '0;
            grant     <= '0;
            for (int i = 0; i < LANES; i++) begin
                hold[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (valid_in[i] && in_ready[i]) begin
                    pend[i] <= 1'b1;
                    hold[i] <= data_in[i*DATA_WIDTH +: DATA_WIDTH];
                end else if (win[i]) begin
                    pend[i] <= 1'b0;
                end
            end
            // A stall freezes the whole output register and the pointer.
            if (out_ready) begin
                if (any) begin
                    data_out  <= hold[win_idx];
                    selector  <= win_idx;
                    grant     <= onehot2(win_idx);
                    valid_out <= 1'b1;
                    last      <= win_idx;
                end else begin
                    valid_out <= 1'b0;
                    grant     <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Scoreboard bench for mux_rr_scheduler: a lane-buffer reference model predicts
// grants into a queue while an independent monitor checks every output edge.
module tb_mux_rr_scheduler;

    typedef struct {
        int         lane;
        logic [7:0] data;
    } exp_t;

    logic        clk_4f = 1'b0;
    logic        reset;
    logic [3:0]  valid_in;
    logic [31:0] data_in;
    logic [3:0]  in_ready;
    logic        out_ready;
    logic        valid_out;
    logic [7:0]  data_out;
    logic [1:0]  selector;
    logic [3:0]  grant;

    int total = 0;
    int bad   = 0;

    exp_t       exp_q[$];
    bit   [3:0] mpend;
    logic [7:0] mhold [4];
    int         mlast;
    bit         minit = 0;

    mux_rr_scheduler dut (
        .clk_4f    (clk_4f),
        .reset     (reset),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .valid_out (valid_out),
        .data_out  (data_out),
        .selector  (selector),
        .grant     (grant)
    );

    always #5 clk_4f = ~clk_4f;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one cycle of inputs and advances the reference model for that edge.
    task automatic applyStimulus(input logic r, input logic [3:0] v, input logic [31:0] d, input logic o);
        int         w;
        logic [3:0] er;
        @(negedge clk_4f);
        reset     = r;
        valid_in  = v;
        data_in   = d;
        out_ready = o;
        #1;
        w = -1;
        if (o) begin
            for (int k = 1; k <= 4; k++) begin
                if (w < 0 && mpend[(mlast + k) % 4]) w = (mlast + k) % 4;
            end
        end
        for (int i = 0; i < 4; i++) er[i] = !mpend[i] || (w == i);
        if (minit) checkOutput("in_ready", {28'd0, in_ready}, {28'd0, er});
        if (r) begin
            mpend = '0;
            for (int i = 0; i < 4; i++) mhold[i] = 8'h00;
            mlast = 3;
            minit = 1;
            exp_q.delete();
        end else begin
            if (w >= 0) begin
                exp_q.push_back('{lane: w, data: mhold[w]});
                mpend[w] = 0;
                mlast = w;
            end
            for (int i = 0; i < 4; i++) begin
                if (v[i] && er[i]) begin
                    mpend[i] = 1;
                    mhold[i] = d[i*8 +: 8];
                end
            end
        end
    endtask

    // Monitor: inspects outputs just after each rising edge.
    initial begin
        logic [14:0] snap;
        exp_t        e;
        snap = '0;
        forever begin
            @(posedge clk_4f);
            #1;
            if (reset === 1'b1) begin
                checkOutput("reset_outputs", {17'd0, valid_out, data_out, selector, grant}, 32'd0);
            end else if (out_ready === 1'b1) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    checkOutput("valid_out", {31'd0, valid_out}, 32'd1);
                    checkOutput("data_out", {24'd0, data_out}, {24'd0, e.data});
                    checkOutput("selector", {30'd0, selector}, e.lane);
                    checkOutput("grant", {28'd0, grant}, 32'd1 << e.lane);
                end else begin
                    checkOutput("idle_valid_grant", {27'd0, valid_out, grant}, 32'd0);
                end
            end else if (out_ready === 1'b0) begin
                checkOutput("stall_frozen", {17'd0, valid_out, data_out, selector, grant}, {17'd0, snap});
            end
            snap = {valid_out, data_out, selector, grant};
        end
    end

    initial begin
        logic [7:0] cnt;
        $display("[TB] starting mux_rr_scheduler bench");
        reset = 1'b1; valid_in = 4'h0; data_in = 32'h0; out_ready = 1'b1;

        // Reset with all lanes asserting valid, then idle.
        applyStimulus(1'b1, 4'hF, 32'h12345678, 1'b1);
        applyStimulus(1'b1, 4'hF, 32'h9ABCDEF0, 1'b1);
        applyStimulus(1'b0, 4'h0, 32'h0, 1'b1);

        // Single lane 2 word.
        applyStimulus(1'b0, 4'b0100, 32'h00FF0000, 1'b1);
        repeat (3) applyStimulus(1'b0, 4'h0, 32'h0, 1'b1);

        // All lanes in the same cycle.
        applyStimulus(1'b0, 4'hF, 32'hFDFF01EE, 1'b1);
        repeat (6) applyStimulus(1'b0, 4'h0, 32'h0, 1'b1);

        // Lane 2 idle: grants rotate over 0,1,3 without gaps.
        cnt = 8'h10;
        repeat (12) begin
            applyStimulus(1'b0, 4'b1011, {cnt + 8'd3, cnt + 8'd2, cnt + 8'd1, cnt}, 1'b1);
            cnt = cnt + 8'd4;
        end
        repeat (4) applyStimulus(1'b0, 4'h0, 32'h0, 1'b1);

        // Stall with lanes 0 and 1 pending, empty lanes still capturing.
        applyStimulus(1'b0, 4'b0011, 32'h0000_B2A1, 1'b0);
        applyStimulus(1'b0, 4'b0000, 32'h0, 1'b0);
        applyStimulus(1'b0, 4'b0000, 32'h0, 1'b0);
        applyStimulus(1'b0, 4'b1100, 32'hD4C3_0000, 1'b0);
        repeat (6) applyStimulus(1'b0, 4'h0, 32'h0, 1'b1);

        // Reset after the second word of a four-lane burst.
        applyStimulus(1'b0, 4'hF, 32'hFDFF01EE, 1'b1);
        applyStimulus(1'b0, 4'h0, 32'h0, 1'b1);
        applyStimulus(1'b0, 4'h0, 32'h0, 1'b1);
        applyStimulus(1'b1, 4'h0, 32'h0, 1'b1);
        applyStimulus(1'b0, 4'h0, 32'h0, 1'b1);
        applyStimulus(1'b0, 4'hF, 32'h44332211, 1'b1);
        repeat (6) applyStimulus(1'b0, 4'h0, 32'h0, 1'b1);

        // Randomized traffic with occasional stalls and resets.
        repeat (400) begin
            applyStimulus($urandom_range(0, 99) == 0,
                          4'($urandom),
                          $urandom,
                          $urandom_range(0, 3) != 0);
        end
        repeat (6) applyStimulus(1'b0, 4'h0, 32'h0, 1'b1);

        checkOutput("queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_rr_scheduler.md
# mux_rr_scheduler

Round-robin scheduler feeding the 4-to-1 lane multiplexer of the serialising datapath. It accepts up to four independent valid/data lanes, buffers one word per lane, and grants the shared output to one pending lane per cycle in rotating order. It drives the mux `selector` and the registered merged stream. Idle or invalid lanes are skipped rather than consuming a slot.

## Interface
- `DATA_WIDTH`, 8, width of each lane word.
- `LANES`, 4, number of lanes; fixed at 4 for this revision.
- `clk_4f`  input  1  single clock; all state updates on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `valid_in`  input  4  per-lane valid; bit i qualifies lane i.
- `data_in`  input  4*DATA_WIDTH  lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `in_ready`  output  4  lane i may present a word this cycle.
- `out_ready`  input  1  downstream accepts `data_out` this cycle.
- `valid_out`  output  1  `data_out` holds a granted word.
- `data_out`  output  DATA_WIDTH  granted word, registered.
- `selector`  output  2  index of the lane granted on the current output word.
- `grant`  output  4  one-hot copy of `selector`; zero when `valid_out`=0.

## Operation
- Per-lane holding register: `pend[i]` flag plus `hold[i]` word.
- Capture: lane i transfers when `valid_in[i]` && `in_ready[i]`. The word is loaded into `hold[i]` and `pend[i]` is set at that edge.
- `in_ready[i] = !pend[i] || win[i]`. `win` is this cycle's grant, so a lane refills in the same cycle it drains. `in_ready` is combinational from state and `out_ready` only; it never depends on `valid_in`.
- Arbitration runs each cycle with `out_ready`=1 and at least one `pend` bit set.
  - Search starts at lane `(last+1) mod 4` and proceeds upward circularly.
  - The first pending lane wins.
  - `last` becomes the winner.
- On a win at the edge:
  - `data_out <= hold[w]`, `selector <= w`, `grant <= onehot(w)`, `valid_out <= 1`.
  - `pend[w]` is cleared unless the same lane is captured at the same edge; then it stays set with the new word.
- `out_ready`=1 with no pend bit set: `valid_out <= 0`, `grant <= 0`. `data_out` and `selector` hold their values.
- `out_ready`=0 (stall): no grant, and `win`=0. `valid_out`, `data_out`, `selector`, `grant` and `last` all hold. Lanes with `pend`=1 see `in_ready`=0. Empty lanes still capture.
- Fairness: a continuously pending lane is granted within 4 granting cycles.
- Reset:
  - `pend`=0, `hold`=0, `valid_out`=0, `data_out`=0, `selector`=0, `grant`=0.
  - `last`=3, so the first search starts at lane 0.
  - Reset mid-operation discards all buffered words. Reset wins over simultaneous capture or grant.

## Timing
- Latency, uncontested lane: word sampled at edge N, `pend` set after N, granted at edge N+1, visible on `data_out` after edge N+1.
- Throughput: one word per cycle while `out_ready`=1. Each lane sustains one word per cycle when it is the only active lane.
- With all four lanes continuously valid, the grant order is 0,1,2,3,0,… and each lane sustains one word per 4 cycles.
- `selector`, `grant`, `valid_out` and `data_out` change on the same edge and are always mutually consistent.
- No combinational path from `valid_in` or `data_in` to any output.

## Structure
- Shared package `mux_pkg`:
  - constants `DATA_WIDTH`, `LANES`, `SEL_WIDTH`=2.
  - function `onehot2(sel)` returning a 4-bit one-hot value.
- Sub-module `rr_arbiter4`: combinational rotating-priority picker.
  - Inputs: `req[3:0]`, `last[1:0]`, `en`.
  - Outputs: `win[3:0]` (one-hot or zero), `win_idx[1:0]`, `any`.
- The top level holds the lane registers, the `last` pointer and the output register.

## Test plan
1. **Reset then idle.** Assert `reset` for 2 cycles with `valid_in`=4'b1111.
   - During reset: all outputs 0.
   - After release: `in_ready`=4'b1111, `valid_out`=0.
2. **Single lane.** Lane 2 presents 8'hFF for one cycle.
   - One edge later: `valid_out`=1, `data_out`=8'hFF, `selector`=2, `grant`=4'b0100.
   - Next cycle: `valid_out`=0.
3. **All lanes valid, same cycle.** Present 8'hEE, 8'h01, 8'hFF, 8'hFD, then deassert.
   - Outputs: EE(0), 01(1), FF(2), FD(3) on 4 consecutive cycles, then `valid_out`=0.
4. **Skip invalid lanes.** Drive `valid_in`=4'b1011 continuously with incrementing data.
   - Grant order repeats 0,1,3.
   - Lane 2 is never selected.
   - No idle cycles between words.
5. **Stall.** Lanes 0 and 1 are pending; hold `out_ready`=0 for 3 cycles.
   - Outputs frozen throughout.
   - `in_ready[1:0]`=0, `in_ready[3:2]`=1.
   - After release: lanes 0 then 1 are output, with no word lost or duplicated.
6. **Reset mid-stream.** During test 3, assert `reset` after the 8'h01 output.
   - Next cycle: `valid_out`=0.
   - 8'hFF and 8'hFD are never output.
   - The first grant after release comes from lane 0.
